xtoken_link_arbiter: RTL and testbench

- Shares one 9-bit token sink (an output token FIFO feeding a link) between NUM_REQ source token FIFOs.
- Each source FIFO is first-word-fall-through: its dout is valid whenever empty=0, and rd_en pops the head.
- Arbitration is round-robin, one packet at a time. A grant is held until an END or PAUSE control token has been forwarded, so packets from different sources are never interleaved.

---
 rtl/xtoken_link_arbiter.sv | 141 ++++++++++++++
 tb/tb_xtoken_link_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xtoken_link_arbiter.sv
// xtoken_link_arbiter
// Round-robin arbiter that lets NUM_REQ first-word-fall-through token FIFOs
// share one 9-bit token sink, one whole packet at a time. A grant is only
// released after an END or PAUSE control token has been forwarded, so packets
// from different sources never interleave on the link.

module xtoken_link_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          REQ_IDX_WIDTH = 2,
  parameter logic [7:0]  CT_END        = 8'h01,
  parameter logic [7:0]  CT_PAUSE      = 8'h02
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_empty,
  input  logic [9*NUM_REQ-1:0]     req_dout,
  output logic [NUM_REQ-1:0]       req_rd_en,
  input  logic                     out_full,
  output logic [8:0]               out_din,
  output logic                     out_wr_en,
  output logic                     grant_valid,
  output logic [REQ_IDX_WIDTH-1:0] grant_idx,
  output logic [15:0]              tok_count
);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  // After reset the pointer sits on the last source so source 0 wins first.
  localparam logic [REQ_IDX_WIDTH-1:0] LAST_PTR_RESET = REQ_IDX_WIDTH'(NUM_REQ - 1);

  state_t                   state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [REQ_IDX_WIDTH-1:0] last_ptr_q, last_ptr_d;
  logic [15:0]              tok_count_q, tok_count_d;

  logic [8:0]               head_tok;
  logic                     head_empty;
  logic                     xfer;
  logic                     release_tok;
  logic                     any_req;
  logic [REQ_IDX_WIDTH-1:0] rr_winner;
  logic                     found_hi;
  logic                     found_lo;
  logic [REQ_IDX_WIDTH-1:0] win_hi;
  logic [REQ_IDX_WIDTH-1:0] win_lo;

  // Select the head token and empty flag of the currently granted source.
  always_comb begin
    head_tok   = '0;
    head_empty = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == REQ_IDX_WIDTH'(i)) begin
        head_tok   = req_dout[9*i +: 9];
        head_empty = req_empty[i];
      end
    end
  end

  // A token moves only while granted, the source has data and the sink has
  // room; reset suppresses movement so nothing is popped in the reset cycle.
  assign xfer        = (state_q == ST_XFER) && !reset && !head_empty && !out_full;
  assign release_tok = xfer && head_tok[8] &&
                       ((head_tok[7:0] == CT_END) || (head_tok[7:0] == CT_PAUSE));

  // Round-robin search: first look above last_ptr, then wrap to the bottom.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_hi && !req_empty[j] && (REQ_IDX_WIDTH'(j) > last_ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = REQ_IDX_WIDTH'(j);
      end
      if (!found_lo && !req_empty[j] && (REQ_IDX_WIDTH'(j) <= last_ptr_q)) begin
        found_lo = 1'b1;
        win_lo   = REQ_IDX_WIDTH'(j);
      end
    end
    any_req   = found_hi || found_lo;
    rr_winner = found_hi ? win_hi : win_lo;
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      last_ptr_q  <= LAST_PTR_RESET;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_ptr_q  <= last_ptr_d;
      tok_count_q <= tok_count_d;
    end
  end

  // Next-state logic: grant on any request, release after a closing token.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_ptr_d  = last_ptr_q;
    tok_count_d = xfer ? (tok_count_q + 16'd1) : tok_count_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_XFER;
          grant_idx_d = rr_winner;
        end
      end
      ST_XFER: begin
        if (release_tok) begin
          state_d    = ST_IDLE;
          last_ptr_d = grant_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: pop and write strobes track xfer, data follows the grant.
  always_comb begin
    grant_valid = (state_q == ST_XFER);
    grant_idx   = grant_idx_q;
    tok_count   = tok_count_q;
    out_wr_en   = xfer;
    out_din     = grant_valid ? head_tok : 9'd0;
    req_rd_en   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx_q == REQ_IDX_WIDTH'(k)) begin
        req_rd_en[k] = xfer;
      end
    end
  end

endmodule

// File: tb/tb_xtoken_link_arbiter.sv
// tb_xtoken_link_arbiter
// Directed bench for the token link arbiter. Each source FIFO is modelled as a
// small array with read/write pointers; the bench pops on the DUT's rd_en and
// checks grants, tokens and counts against hand-computed values.

module tb_xtoken_link_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IW      = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req_empty;
  logic [9*NUM_REQ-1:0] req_dout;
  logic [NUM_REQ-1:0] req_rd_en;
  logic               out_full;
  logic [8:0]         out_din;
  logic               out_wr_en;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;
  logic [15:0]        tok_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] src_mem [NUM_REQ][16];
  int         src_wr  [NUM_REQ];
  int         src_rd  [NUM_REQ];
  logic [8:0] wlog [$];

  logic [NUM_REQ-1:0] s_rd;
  logic               s_wr;
  logic [8:0]         s_din;
  logic               s_gv;
  logic [IW-1:0]      s_gi;
  logic [15:0]        s_cnt;

  xtoken_link_arbiter #(
    .NUM_REQ(NUM_REQ),
    .REQ_IDX_WIDTH(IW),
    .CT_END(8'h01),
    .CT_PAUSE(8'h02)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_empty(req_empty),
    .req_dout(req_dout),
    .req_rd_en(req_rd_en),
    .out_full(out_full),
    .out_din(out_din),
    .out_wr_en(out_wr_en),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .tok_count(tok_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic push_tok(input int src, input logic [8:0] tok);
    src_mem[src][src_wr[src]] = tok;
    src_wr[src]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        req_empty[i]       = 1'b0;
        req_dout[9*i +: 9] = src_mem[i][src_rd[i]];
      end else begin
        req_empty[i]       = 1'b1;
        req_dout[9*i +: 9] = 9'd0;
      end
    end
  endtask

  // One clock: drive FIFO heads at negedge, sample outputs, pop after posedge.
  task automatic cycle();
    logic illegal;
    @(negedge clk);
    drive_inputs();
    #1;
    s_rd  = req_rd_en;
    s_wr  = out_wr_en;
    s_din = out_din;
    s_gv  = grant_valid;
    s_gi  = grant_idx;
    s_cnt = tok_count;
    illegal = 1'b0;
    if (s_wr && out_full) illegal = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_rd[i] && req_empty[i]) illegal = 1'b1;
    end
    checks++;
    if (illegal) begin
      errors++;
      $display("[TB] FAIL protocol: wr=%0b full=%0b rd=%b empty=%b required no write when full and no pop when empty",
               s_wr, out_full, s_rd, req_empty);
    end
    if (s_wr) wlog.push_back(s_din);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_rd[i] && (src_rd[i] < src_wr[i])) src_rd[i]++;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    wlog.delete();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    checks++; if (s_gv !== 1'b0) begin errors++; $display("[TB] FAIL reset_gv: got %0b want 0", s_gv); end
    checks++; if (s_gi !== 2'd0) begin errors++; $display("[TB] FAIL reset_gi: got %0d want 0", s_gi); end
    checks++; if (s_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", s_cnt); end
    checks++; if (s_wr !== 1'b0 || s_rd !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobes: wr=%0b rd=%b want 0/0000", s_wr, s_rd); end
    checks++; if (s_din !== 9'h000) begin errors++; $display("[TB] FAIL reset_din: got %h want 000", s_din); end
  endtask

  task automatic test_single_packet();
    logic [8:0] exp_tok [3];
    exp_tok[0] = 9'h041; exp_tok[1] = 9'h042; exp_tok[2] = 9'h101;
    do_reset();
    for (int k = 0; k < 3; k++) push_tok(2, exp_tok[k]);
    cycle();
    checks++; if (s_gv !== 1'b0) begin errors++; $display("[TB] FAIL single_arb_gv: got %0b want 0", s_gv); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (s_gv !== 1'b1 || s_gi !== 2'd2) begin errors++; $display("[TB] FAIL single_grant[%0d]: gv=%0b gi=%0d want 1/2", k, s_gv, s_gi); end
      checks++; if (s_wr !== 1'b1 || s_din !== exp_tok[k]) begin errors++; $display("[TB] FAIL single_tok[%0d]: wr=%0b din=%h want 1/%h", k, s_wr, s_din, exp_tok[k]); end
    end
    cycle();
    checks++; if (s_gv !== 1'b0) begin errors++; $display("[TB] FAIL single_release: gv=%0b want 0", s_gv); end
    checks++; if (s_cnt !== 16'd3) begin errors++; $display("[TB] FAIL single_cnt: got %0d want 3", s_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_tok(i, 9'h0AA);
      push_tok(i, 9'h101);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      cycle();
      checks++; if (s_gv !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle[%0d]: gv=%0b want 0", k, s_gv); end
      cycle();
      checks++; if (s_gv !== 1'b1 || s_gi !== IW'(k) || s_din !== 9'h0AA) begin errors++; $display("[TB] FAIL rr_grant[%0d]: gv=%0b gi=%0d din=%h want 1/%0d/0aa", k, s_gv, s_gi, s_din, k); end
      cycle();
      checks++; if (s_wr !== 1'b1 || s_din !== 9'h101) begin errors++; $display("[TB] FAIL rr_end[%0d]: wr=%0b din=%h want 1/101", k, s_wr, s_din); end
    end
    cycle();
    checks++; if (s_cnt !== 16'd8 || s_gv !== 1'b0) begin errors++; $display("[TB] FAIL rr_cnt: cnt=%0d gv=%0b want 8/0", s_cnt, s_gv); end
  endtask

  task automatic test_no_interleave();
    do_reset();
    push_tok(0, 9'h011);
    push_tok(1, 9'h0B1);
    push_tok(1, 9'h101);
    cycle();
    cycle();
    checks++; if (s_gi !== 2'd0 || s_din !== 9'h011 || s_wr !== 1'b1) begin errors++; $display("[TB] FAIL ni_first: gi=%0d din=%h wr=%0b want 0/011/1", s_gi, s_din, s_wr); end
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++; if (s_gv !== 1'b1 || s_gi !== 2'd0 || s_wr !== 1'b0) begin errors++; $display("[TB] FAIL ni_hold[%0d]: gv=%0b gi=%0d wr=%0b want 1/0/0", k, s_gv, s_gi, s_wr); end
    end
    checks++; if (src_rd[1] !== 0) begin errors++; $display("[TB] FAIL ni_src1_untouched: pops=%0d want 0", src_rd[1]); end
    push_tok(0, 9'h102);
    cycle();
    checks++; if (s_gi !== 2'd0 || s_din !== 9'h102 || s_wr !== 1'b1) begin errors++; $display("[TB] FAIL ni_close: gi=%0d din=%h wr=%0b want 0/102/1", s_gi, s_din, s_wr); end
    cycle();
    cycle();
    checks++; if (s_gv !== 1'b1 || s_gi !== 2'd1 || s_din !== 9'h0B1) begin errors++; $display("[TB] FAIL ni_next: gv=%0b gi=%0d din=%h want 1/1/0b1", s_gv, s_gi, s_din); end
    checks++; if (wlog.size() != 3 || wlog[0] !== 9'h011 || wlog[1] !== 9'h102 || wlog[2] !== 9'h0B1) begin errors++; $display("[TB] FAIL ni_order: got %0d writes, want 011 102 0b1", wlog.size()); end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_tok [4];
    exp_tok[0] = 9'h021; exp_tok[1] = 9'h022; exp_tok[2] = 9'h023; exp_tok[3] = 9'h101;
    do_reset();
    for (int k = 0; k < 4; k++) push_tok(1, exp_tok[k]);
    cycle();
    cycle();
    out_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (s_wr !== 1'b0 || s_rd !== 4'b0000 || s_gv !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall[%0d]: wr=%0b rd=%b gv=%0b want 0/0000/1", k, s_wr, s_rd, s_gv); end
      checks++; if (s_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_cnt_frozen[%0d]: got %0d want 1", k, s_cnt); end
    end
    out_full = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    cycle();
    checks++; if (s_cnt !== 16'd4 || s_gv !== 1'b0) begin errors++; $display("[TB] FAIL bp_final: cnt=%0d gv=%0b want 4/0", s_cnt, s_gv); end
    checks++; if (wlog.size() != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d writes want 4", wlog.size()); end
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      checks++; if (wlog[k] !== exp_tok[k]) begin errors++; $display("[TB] FAIL bp_tok[%0d]: got %h want %h", k, wlog[k], exp_tok[k]); end
    end
  endtask

  task automatic test_non_closing();
    do_reset();
    push_tok(3, 9'h103);
    push_tok(3, 9'h055);
    push_tok(3, 9'h102);
    cycle();
    cycle();
    checks++; if (s_gi !== 2'd3 || s_din !== 9'h103) begin errors++; $display("[TB] FAIL nc_first: gi=%0d din=%h want 3/103", s_gi, s_din); end
    push_tok(1, 9'h0C1);
    push_tok(1, 9'h101);
    push_tok(0, 9'h0C0);
    push_tok(0, 9'h101);
    cycle();
    checks++; if (s_gv !== 1'b1 || s_gi !== 2'd3 || s_din !== 9'h055) begin errors++; $display("[TB] FAIL nc_hold: gv=%0b gi=%0d din=%h want 1/3/055", s_gv, s_gi, s_din); end
    cycle();
    checks++; if (s_gi !== 2'd3 || s_din !== 9'h102 || s_wr !== 1'b1) begin errors++; $display("[TB] FAIL nc_pause: gi=%0d din=%h wr=%0b want 3/102/1", s_gi, s_din, s_wr); end
    cycle();
    checks++; if (s_gv !== 1'b0) begin errors++; $display("[TB] FAIL nc_release: gv=%0b want 0", s_gv); end
    cycle();
    checks++; if (s_gv !== 1'b1 || s_gi !== 2'd0) begin errors++; $display("[TB] FAIL nc_wrap: gv=%0b gi=%0d want 1/0", s_gv, s_gi); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_tok(0, 9'h0E0);
    push_tok(0, 9'h101);
    push_tok(1, 9'h031);
    push_tok(1, 9'h032);
    push_tok(1, 9'h101);
    for (int k = 0; k < 4; k++) cycle();
    cycle();
    checks++; if (s_gi !== 2'd1 || s_din !== 9'h031 || s_wr !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: gi=%0d din=%h wr=%0b want 1/031/1", s_gi, s_din, s_wr); end
    push_tok(0, 9'h0D0);
    push_tok(0, 9'h101);
    reset = 1'b1;
    cycle();
    checks++; if (s_rd !== 4'b0000 || s_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_pop: rd=%b wr=%0b want 0000/0", s_rd, s_wr); end
    checks++; if (src_rd[1] !== 1) begin errors++; $display("[TB] FAIL rst_src1_pops: got %0d want 1", src_rd[1]); end
    reset = 1'b0;
    cycle();
    checks++; if (s_gv !== 1'b0 || s_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_state: gv=%0b cnt=%0d want 0/0", s_gv, s_cnt); end
    cycle();
    checks++; if (s_gv !== 1'b1 || s_gi !== 2'd0 || s_din !== 9'h0D0) begin errors++; $display("[TB] FAIL rst_priority: gv=%0b gi=%0d din=%h want 1/0/0d0", s_gv, s_gi, s_din); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset     = 1'b1;
    out_full  = 1'b0;
    req_empty = '1;
    req_dout  = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_non_closing();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
